// File: rtl/mem_ext_arbiter.sv
// ============================================================================
// Module      : mem_ext_arbiter
// Description : Round-robin two-requester arbiter/sequencer in front of the
//               mem_ext W0/R0 ports, with per-requester read response buffers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ext_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 64
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [ADDR_W-1:0]     req_addr_0,
    input  logic [ADDR_W-1:0]     req_addr_1,
    input  logic [DATA_W-1:0]     req_data_0,
    input  logic [DATA_W-1:0]     req_data_1,
    input  logic [DATA_W/8-1:0]   req_mask_0,
    input  logic [DATA_W/8-1:0]   req_mask_1,

    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_W-1:0]     rsp_data_0,
    output logic [DATA_W-1:0]     rsp_data_1,

    output logic                  W0_en,
    output logic [ADDR_W-1:0]     W0_addr,
    output logic [DATA_W-1:0]     W0_data,
    output logic [DATA_W/8-1:0]   W0_mask,
    output logic                  R0_en,
    output logic [ADDR_W-1:0]     R0_addr,
    input  logic [DATA_W-1:0]     R0_data
);

    localparam int MASK_W = DATA_W / 8;

    logic                 r_last;
    logic [1:0]           r_inflight;
    logic [1:0]           w_hold_valid;
    logic [1:0]           w_slot_free;
    logic [1:0]           w_elig;
    logic [1:0]           w_grant;
    logic                 w_win;
    logic                 w_win_write;
    logic                 w_wr_go;
    logic                 w_rd_go;
    logic [ADDR_W-1:0]    w_win_addr;
    logic [DATA_W-1:0]    w_win_data;
    logic [MASK_W-1:0]    w_win_mask;

    logic [ADDR_W-1:0]    r_w0_addr;
    logic [DATA_W-1:0]    r_w0_data;
    logic [MASK_W-1:0]    r_w0_mask;
    logic [ADDR_W-1:0]    r_r0_addr;

    // Per-requester response path: a hold buffer catches R0_data when the
    // requester stalls, so the other requester's next read cannot clobber it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            logic              r_hold_valid;
            logic [DATA_W-1:0] r_hold_data;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_hold_valid <= 1'b0;
                    r_hold_data  <= '0;
                end else if (r_hold_valid && rsp_ready[gi]) begin
                    r_hold_valid <= 1'b0;
                end else if (r_inflight[gi] && !rsp_ready[gi]) begin
                    r_hold_valid <= 1'b1;
                    r_hold_data  <= R0_data;
                end
            end

            assign w_hold_valid[gi] = r_hold_valid;
            assign w_slot_free[gi]  = !r_hold_valid && (!r_inflight[gi] || rsp_ready[gi]);
            assign w_elig[gi]       = req_valid[gi] && (req_write[gi] || w_slot_free[gi]);
            assign rsp_valid[gi]    = r_hold_valid || r_inflight[gi];
        end
    endgenerate

    assign rsp_data_0 = w_hold_valid[0] ? g_rsp[0].r_hold_data : R0_data;
    assign rsp_data_1 = w_hold_valid[1] ? g_rsp[1].r_hold_data : R0_data;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        w_grant = 2'b00;
        w_win   = 1'b0;
        if (!reset) begin
            case (w_elig)
                2'b01: begin
                    w_grant = 2'b01;
                    w_win   = 1'b0;
                end
                2'b10: begin
                    w_grant = 2'b10;
                    w_win   = 1'b1;
                end
                2'b11: begin
                    w_win   = ~r_last;
                    w_grant = r_last ? 2'b01 : 2'b10;
                end
                default: begin
                    w_grant = 2'b00;
                    w_win   = 1'b0;
                end
            endcase
        end
    end

    assign w_win_write = req_write[w_win];
    assign w_win_addr  = w_win ? req_addr_1 : req_addr_0;
    assign w_win_data  = w_win ? req_data_1 : req_data_0;
    assign w_win_mask  = w_win ? req_mask_1 : req_mask_0;

    assign w_wr_go = (|w_grant) && w_win_write;
    assign w_rd_go = (|w_grant) && !w_win_write;

    assign req_ready = w_grant;
    assign W0_en     = w_wr_go;
    assign R0_en     = w_rd_go;

    // Address/data outputs keep their last driven value when idle.
    assign W0_addr = w_wr_go ? w_win_addr : r_w0_addr;
    assign W0_data = w_wr_go ? w_win_data : r_w0_data;
    assign W0_mask = w_wr_go ? w_win_mask : r_w0_mask;
    assign R0_addr = w_rd_go ? w_win_addr : r_r0_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last     <= 1'b1;
            r_inflight <= 2'b00;
            r_w0_addr  <= '0;
            r_w0_data  <= '0;
            r_w0_mask  <= '0;
            r_r0_addr  <= '0;
        end else begin
            if (|w_grant) begin
                r_last <= w_win;
            end
            r_inflight <= w_grant & ~req_write;
            if (w_wr_go) begin
                r_w0_addr <= w_win_addr;
                r_w0_data <= w_win_data;
                r_w0_mask <= w_win_mask;
            end
            if (w_rd_go) begin
                r_r0_addr <= w_win_addr;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_ext_arbiter.sv
// ============================================================================
// Module      : tb_mem_ext_arbiter
// Description : Scoreboard bench for mem_ext_arbiter with a behavioural
//               mem_ext model on the W0/R0 ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_ext_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [27:0] req_addr_0, req_addr_1;
    logic [63:0] req_data_0, req_data_1;
    logic [7:0]  req_mask_0, req_mask_1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [63:0] rsp_data_0, rsp_data_1;
    logic        W0_en;
    logic [27:0] W0_addr;
    logic [63:0] W0_data;
    logic [7:0]  W0_mask;
    logic        R0_en;
    logic [27:0] R0_addr;
    logic [63:0] R0_data;

    mem_ext_arbiter #(.ADDR_W(28), .DATA_W(64)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
        .req_data_0(req_data_0), .req_data_1(req_data_1),
        .req_mask_0(req_mask_0), .req_mask_1(req_mask_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1),
        .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data), .W0_mask(W0_mask),
        .R0_en(R0_en), .R0_addr(R0_addr), .R0_data(R0_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] d;
        int          c;
        bit          lat;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    int   grant_log[$];

    // Behavioural main memory: unwritten locations read a pattern of their address.
    logic [63:0] mem [logic [27:0]];

    function automatic logic [63:0] dflt(input logic [27:0] a);
        return {4'hA, a, 4'h5, a};
    endfunction

    function automatic logic [63:0] mem_rd(input logic [27:0] a);
        if (mem.exists(a)) return mem[a];
        return dflt(a);
    endfunction

    always @(posedge clock) begin
        logic [63:0] cur;
        if (W0_en) begin
            cur = mem_rd(W0_addr);
            for (int b = 0; b < 8; b++)
                if (W0_mask[b]) cur[b*8 +: 8] = W0_data[b*8 +: 8];
            mem[W0_addr] = cur;
        end
        if (R0_en) R0_data <= mem_rd(R0_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_rsp(input int i, input logic [63:0] d);
        exp_t e;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            n_cmp++;
            n_err++;
            $display("FAIL rsp%0d_unexpected: got data %h expected no response (cycle %0d)", i, d, cyc);
            return;
        end
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("rsp%0d_data", i), d, e.d);
        if (e.lat) chk($sformatf("rsp%0d_latency_cycle", i), 64'(cyc), 64'(e.c));
    endtask

    // Monitor: consumes a scoreboard entry on every response handshake.
    always @(negedge clock) begin
        if (!reset) begin
            if (rsp_valid[0] && rsp_ready[0]) check_rsp(0, rsp_data_0);
            if (rsp_valid[1] && rsp_ready[1]) check_rsp(1, rsp_data_1);
            if (W0_en || R0_en) chk("w0_r0_exclusive", {63'd0, W0_en & R0_en}, 64'd0);
        end
    end

    task automatic req_op(input int i, input bit wr, input logic [27:0] a,
                          input logic [63:0] d, input logic [7:0] m,
                          input logic [63:0] exp, input bit chk_lat);
        bit   got = 0;
        int   waited = 0;
        exp_t e;
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        if (i == 0) begin
            req_addr_0 = a; req_data_0 = d; req_mask_0 = m;
        end else begin
            req_addr_1 = a; req_data_1 = d; req_mask_1 = m;
        end
        while (!got && waited < 50) begin
            @(negedge clock);
            if (req_ready[i]) begin
                got = 1;
                grant_log.push_back(i);
                if (!wr) begin
                    e.d = exp; e.c = cyc + 1; e.lat = chk_lat;
                    if (i == 0) q0.push_back(e); else q1.push_back(e);
                end
            end
            waited++;
        end
        @(posedge clock); #1;
        req_valid[i] = 1'b0;
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_timeout_req%0d: got no grant expected grant for addr %h", i, a);
        end
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[28'h10] = 64'h1122334455667788;
        mem[28'h20] = 64'hA5A55A5A_01234567;
        reset = 1'b1;
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr_0 = 28'h5; req_addr_1 = 28'h6;
        req_data_0 = '0; req_data_1 = '0;
        req_mask_0 = '0; req_mask_1 = '0;
        rsp_ready = 2'b11;

        // Reset state, with reads pending: nothing may be granted or enabled.
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_W0_en", 64'(W0_en), 64'd0);
        chk("reset_R0_en", 64'(R0_en), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        req_valid = 2'b00;
        step();

        // Single reads; requester 1 last so the contention tie goes to 0.
        req_op(0, 0, 28'h10, '0, '0, 64'h1122334455667788, 1);
        step();
        req_op(1, 0, 28'h11, '0, '0, dflt(28'h11), 1);
        repeat (2) step();

        // Contention: alternating grants starting with requester 0.
        grant_log.delete();
        fork
            begin
                for (int k = 0; k < 4; k++)
                    req_op(0, 0, 28'h100 + 28'(k), '0, '0, dflt(28'h100 + 28'(k)), 1);
            end
            begin
                for (int k = 0; k < 4; k++)
                    req_op(1, 0, 28'h200 + 28'(k), '0, '0, dflt(28'h200 + 28'(k)), 1);
            end
        join
        chk("contention_grant_count", 64'(grant_log.size()), 64'd8);
        if (grant_log.size() == 8)
            for (int k = 0; k < 8; k++)
                chk($sformatf("contention_grant_%0d", k), 64'(grant_log[k]), 64'(k % 2));
        repeat (2) step();

        // Masked write then read-back of the same address.
        req_op(1, 1, 28'h20, 64'hDEADBEEF_CAFEF00D, 8'h0F, '0, 0);
        req_op(1, 0, 28'h20, '0, '0, 64'hA5A55A5A_CAFEF00D, 1);
        repeat (2) step();

        // Backpressure on requester 0 while requester 1 keeps reading.
        rsp_ready[0] = 1'b0;
        fork
            begin
                req_op(0, 0, 28'h40, '0, '0, dflt(28'h40), 0);
                fork
                    req_op(0, 0, 28'h41, '0, '0, dflt(28'h41), 1);
                    begin
                        for (int k = 0; k < 3; k++) begin
                            @(negedge clock);
                            chk($sformatf("bp_rsp_valid0_%0d", k), 64'(rsp_valid[0]), 64'd1);
                            chk($sformatf("bp_rsp_data0_%0d", k), rsp_data_0, dflt(28'h40));
                            chk($sformatf("bp_req_ready0_%0d", k), 64'(req_ready[0]), 64'd0);
                        end
                        @(posedge clock); #1;
                        rsp_ready[0] = 1'b1;
                    end
                join
            end
            begin
                for (int k = 0; k < 4; k++)
                    req_op(1, 0, 28'h300 + 28'(k), '0, '0, dflt(28'h300 + 28'(k)), 1);
            end
        join
        repeat (2) step();

        // Write granted while the requester's hold buffer is full.
        rsp_ready[0] = 1'b0;
        req_op(0, 0, 28'h50, '0, '0, dflt(28'h50), 0);
        step();
        fork
            req_op(0, 1, 28'h58, 64'h0123456789ABCDEF, 8'hFF, '0, 0);
            begin
                @(negedge clock);
                chk("blocked_wr_req_ready0", 64'(req_ready[0]), 64'd1);
                chk("blocked_wr_W0_en", 64'(W0_en), 64'd1);
                chk("blocked_wr_W0_addr", 64'(W0_addr), 64'h58);
                chk("blocked_wr_rsp_valid0", 64'(rsp_valid[0]), 64'd1);
                chk("blocked_wr_held_data", rsp_data_0, dflt(28'h50));
            end
        join
        rsp_ready[0] = 1'b1;
        step();
        req_op(1, 0, 28'h58, '0, '0, 64'h0123456789ABCDEF, 1);
        repeat (2) step();

        // Reset asserted the cycle after a read grant.
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr_0 = 28'h60;
        @(negedge clock);
        chk("rst_mid_grant", 64'(req_ready[0]), 64'd1);
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_inflight_valid", 64'(rsp_valid[0]), 64'd1);
        @(posedge clock); #1;
        req_valid = 2'b11; req_write = 2'b00;
        @(negedge clock);
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mid_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mid_R0_en", 64'(R0_en), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        grant_log.delete();
        fork
            req_op(0, 0, 28'h70, '0, '0, dflt(28'h70), 1);
            req_op(1, 0, 28'h71, '0, '0, dflt(28'h71), 1);
        join
        chk("post_reset_grant_count", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() > 0) chk("post_reset_first_grant", 64'(grant_log[0]), 64'd0);
        repeat (3) step();

        chk("scoreboard_q0_drained", 64'(q0.size()), 64'd0);
        chk("scoreboard_q1_drained", 64'(q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
